// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory requests and a two-entry output/skid buffer.
// Optional HALT-on-opcode-0x3F behaviour is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] code,
  output logic [ADDR_W-1:0]  code_pc,
  output logic               code_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFull
`ifdef FETCH_HALT_EN
    , StHalt
`endif
  } state_e;

  state_e             state_q;
  logic               req_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] skid_code_q;
  logic [ADDR_W-1:0]  skid_pc_q;
  logic               skid_valid_q;

  logic consume;
  logic accept;
  logic halt_word;

  assign consume = code_valid & ~stall;
  assign accept  = req_q & imem.ack;

`ifdef FETCH_HALT_EN
  assign halt_word = &imem.rdata[INSTR_W-1 -: 6];
`else
  assign halt_word = 1'b0;
`endif

  // Moore outputs: request and address come straight from registers.
  assign imem.req  = req_q;
  assign imem.addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      code         <= '0;
      code_pc      <= '0;
      code_valid   <= 1'b0;
      skid_code_q  <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // Any same-cycle accept is dropped; the PC does not advance.
      state_q      <= StReq;
      req_q        <= 1'b1;
      pc_q         <= redirect_pc;
      code_valid   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          if (accept) begin
            pc_q <= pc_q + ADDR_W'(1);
            if (!code_valid || consume) begin
              code       <= imem.rdata;
              code_pc    <= pc_q;
              code_valid <= 1'b1;
            end else begin
              skid_code_q  <= imem.rdata;
              skid_pc_q    <= pc_q;
              skid_valid_q <= 1'b1;
              state_q      <= StFull;
              req_q        <= 1'b0;
            end
`ifdef FETCH_HALT_EN
            if (halt_word) begin
              state_q <= StHalt;
              req_q   <= 1'b0;
            end
`endif
          end else if (consume) begin
            code_valid <= 1'b0;
          end
        end
        StFull: begin
          if (consume && skid_valid_q) begin
            code         <= skid_code_q;
            code_pc      <= skid_pc_q;
            skid_valid_q <= 1'b0;
            state_q      <= StReq;
            req_q        <= 1'b1;
          end
        end
`ifdef FETCH_HALT_EN
        StHalt: begin
          // No further requests; buffered words drain on consume.
          if (consume) begin
            if (skid_valid_q) begin
              code         <= skid_code_q;
              code_pc      <= skid_pc_q;
              skid_valid_q <= 1'b0;
            end else begin
              code_valid <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // halt_word only steers the FSM when the halt feature is built in.
  logic unused_halt;
  assign unused_halt = halt_word;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit Harvard processor. It owns the program counter, issues word reads to the instruction memory, and presents registered 32-bit instruction words to the decoder's `code` input. A two-entry buffer (output register plus one skid entry) absorbs decode stalls without losing in-flight words. A redirect input reloads the PC for branches and jumps.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction memory word-address width; PC width.
- `INSTR_W`, default 32: instruction word width.
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: read request to instruction memory.
- `imem_addr`, output, ADDR_W: word address of the request; equals PC.
- `imem_ack`, input, 1: read complete. Meaningful only while `imem_req`=1.
- `imem_rdata`, input, INSTR_W: read data, valid when `imem_ack`=1.
- `stall`, input, 1: decode cannot accept a word this cycle.
- `redirect_valid`, input, 1: single-cycle pulse to load a new PC.
- `redirect_pc`, input, ADDR_W: new PC, used when `redirect_valid`=1.
- `code`, output, INSTR_W: instruction word to the decoder.
- `code_pc`, output, ADDR_W: address the current `code` was fetched from.
- `code_valid`, output, 1: `code`/`code_pc` hold a live instruction.

## Operation

- **Consume event:** `code_valid`=1 and `stall`=0 in the same cycle.
- **Accept event:** `imem_req`=1 and `imem_ack`=1 in the same cycle. On accept, PC <= PC+1, wrapping modulo 2^ADDR_W.
- **State machine:** IDLE, REQ, FULL, and HALT (HALT exists only with `FETCH_HALT_EN`).
- **IDLE:** entered only by reset. Goes to REQ on the first clock edge after `rst_n` deasserts.
- **REQ:** `imem_req`=1. The skid entry is always empty in this state. On accept:
  - if the output register is empty or is consumed this cycle: output <= {imem_rdata, PC}; stay in REQ.
  - otherwise (output valid and stalled): skid <= {imem_rdata, PC}; go to FULL.
  - on a consume with no accept, `code_valid` <= 0.
- **FULL:** `imem_req`=0. On consume: output <= skid, skid is cleared, go to REQ. Otherwise hold all state.
- **Redirect:** takes priority over everything else. PC <= `redirect_pc`, output and skid are invalidated, state <= REQ. An accept in the same cycle is discarded and does not increment the PC.
  - `imem_req` may drop without an ack only on redirect. The memory must tolerate abandoned requests.
- **Request stability:** while in REQ, `imem_addr` is stable until accept.
- **Data fields:** `code` and `code_pc` keep their last value when `code_valid`=0.

## Timing

- **Reset values:** `imem_req`=0, `imem_addr`=RESET_PC, `code`=0, `code_pc`=0, `code_valid`=0, skid invalid, state IDLE.
- **Output decode:** `imem_req` and `imem_addr` are Moore outputs of state and PC; there is no combinational path from inputs.
- **Latency:** an accept at cycle n gives `code_valid`=1 at n+1.
- **Throughput:** one word per cycle with a zero-wait memory and no stall.
- **Stall response:** a stall at cycle n with an accept at n fills the skid, and `imem_req`=0 from n+1. The first unstalled cycle consumes the output, and `imem_req` reasserts the next cycle.
- **Redirect response:** `redirect_valid` at n gives `code_valid`=0 and `imem_addr`=`redirect_pc` at n+1.
- **Reset mid-operation:** `rst_n` low at any point forces the reset values immediately; in-flight words are lost.

## Configuration

- **`FETCH_HALT_EN` defined:** when a word with bits [31:26]=6'b111111 is loaded into the output or skid, the state goes to HALT after that edge.
  - HALT: `imem_req`=0; buffered words still drain normally on consume events.
  - Only `redirect_valid` or reset leaves HALT.
- **`FETCH_HALT_EN` undefined:** the HALT state does not exist, and opcode 6'b111111 is fetched like any other word.

## Test plan

- **Reset and stream:** hold `rst_n`=0, release; memory acks every cycle with data = 0x1000_0000+addr, `stall`=0.
  - Required: `imem_req` rises one cycle after release.
  - Required: `code` = 0x1000_0000, 0x1000_0001, … on consecutive cycles, with `code_pc` = 0, 1, ….
- **Stall/skid:** assert `stall` for 3 cycles during streaming.
  - Required: `imem_req` drops after the skid fills.
  - Required: after release, `code` sequence is continuous with no lost or duplicated `code_pc`.
- **Wait-state memory:** ack 2 cycles after each request.
  - Required: `imem_addr` is stable while waiting.
  - Required: each `code_valid` follows its ack by 1 cycle.
- **Redirect:** `redirect_valid` with `redirect_pc`=0x40, in the same cycle as an ack for address 0x07.
  - Required: the word from 0x07 is never presented.
  - Required: next `imem_addr`=0x40; first valid `code_pc`=0x40.
- **PC wrap:** `ADDR_W`=8, redirect to 0xFE.
  - Required: `code_pc` sequence 0xFE, 0xFF, 0x00.
- **Halt (`FETCH_HALT_EN`):** word at address 3 = 0xFC00_0000.
  - Required: `imem_req` stays 0 after that word is loaded; words 0–3 are delivered.
  - Required: a redirect to 0 restarts fetch.
